// File: rtl/alu_64_2_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_64_2_if
//  Description : Operand/result bundle for the alu_64_2 execute-stage ALU.
//                The master drives the op select and operands and the slave
//                returns the registered result and signed-overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_64_2_if #(
   parameter int WIDTH = 64
);
   logic [1:0]       S;   // op select: 00 ADD, 01 SUB, 10 AND, 11 XOR
   logic [WIDTH-1:0] A;   // operand A, signed
   logic [WIDTH-1:0] B;   // operand B, signed
   logic [WIDTH-1:0] Y;   // registered result
   logic             OF;  // registered signed-overflow flag

   modport master (
      output S,
      output A,
      output B,
      input  Y,
      input  OF
   );

   modport slave (
      input  S,
      input  A,
      input  B,
      output Y,
      output OF
   );
endinterface
`default_nettype wire

// File: rtl/alu_64_2.sv
`default_nettype none
// ============================================================================
//  Module      : alu_64_2
//  Description : Two's-complement ALU for the Y86 execute stage. ADD, SUB,
//                AND or XOR on A and B, with the result and a signed-overflow
//                flag registered for one cycle. A new operation is accepted
//                every clock. Arithmetic uses a ripple-carry chain of full
//                adders; SUB inverts B and injects a carry-in of 1.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_64_2 #(
   parameter int WIDTH = 64
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   alu_64_2_if.slave  bus
);

   localparam int          c_msb    = WIDTH - 1;
   localparam logic [1:0]  c_op_add = 2'b00;
   localparam logic [1:0]  c_op_sub = 2'b01;
   localparam logic [1:0]  c_op_and = 2'b10;
   localparam logic [1:0]  c_op_xor = 2'b11;

   // ------------------------------------------------------------------------
   // Adder operand conditioning. Bit 0 of S separates ADD from SUB, so it
   // doubles as the B-invert control and the adder carry-in. For the logic
   // ops the adder output is simply not selected.
   // ------------------------------------------------------------------------
   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;   // w_carry[i] is the carry into bit i

   assign w_sub      = bus.S[0];
   assign w_b_eff    = w_sub ? ~bus.B : bus.B;
   assign w_carry[0] = w_sub;

   // ------------------------------------------------------------------------
   // Ripple-carry chain: one full adder per bit. The carry out of the top
   // bit is never used (overflow is derived from sign bits), so it is not
   // generated at all.
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
         logic w_p;
         assign w_p      = bus.A[i] ^ w_b_eff[i];
         assign w_sum[i] = w_p ^ w_carry[i];
         if (i < WIDTH - 1) begin : g_carry
            assign w_carry[i+1] = (bus.A[i] & w_b_eff[i]) | (w_p & w_carry[i]);
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Signed overflow for the arithmetic ops. Comparing A's sign against the
   // sign of the effective (possibly inverted) B covers both cases at once:
   //   ADD: signs of A and B agree and the sum sign differs from A.
   //   SUB: signs of A and B differ (A and ~B agree) and the result sign
   //        differs from A.
   // ------------------------------------------------------------------------
   logic w_arith_of;

   assign w_arith_of = (bus.A[c_msb] == w_b_eff[c_msb]) &&
                       (w_sum[c_msb] != bus.A[c_msb]);

   // ------------------------------------------------------------------------
   // Result/flag selection.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] w_y;
   logic             w_of;

   // Select the result for the current op; logic ops never overflow.
   always_comb begin
      w_y  = '0;
      w_of = 1'b0;
      case (bus.S)
         c_op_add: begin
            w_y  = w_sum;
            w_of = w_arith_of;
         end
         c_op_sub: begin
            w_y  = w_sum;
            w_of = w_arith_of;
         end
         c_op_and: begin
            w_y  = bus.A & bus.B;
         end
         c_op_xor: begin
            w_y  = bus.A ^ bus.B;
         end
         default: begin
            // S carrying X/Z is a don't-care; keep outputs defined.
            w_y  = '0;
            w_of = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output register: one cycle of latency, cleared immediately on reset so
   // any result in flight is discarded.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_y;
   logic             r_of;

   // Capture result and flag every cycle; async clear on rst_n low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y  <= '0;
         r_of <= 1'b0;
      end else begin
         r_y  <= w_y;
         r_of <= w_of;
      end
   end

   assign bus.Y  = r_y;
   assign bus.OF = r_of;

endmodule
`default_nettype wire

// File: tb/tb_alu_64_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_64_2
//  Description : Self-checking bench for alu_64_2: reset behaviour, a table
//                of boundary vectors, and random operations compared against
//                a wide-integer reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_64_2;

   localparam int          WIDTH = 64;
   localparam logic [63:0] MAX   = 64'h7fff_ffff_ffff_ffff;
   localparam logic [63:0] MIN   = 64'h8000_0000_0000_0000;
   localparam logic [63:0] NEG1  = 64'hffff_ffff_ffff_ffff;
   localparam logic [63:0] NEG2  = 64'hffff_ffff_ffff_fffe;

   logic clk;
   logic rst_n;

   alu_64_2_if #(.WIDTH(WIDTH)) bus ();

   alu_64_2 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  s;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] y;
      logic        of;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] y_exp, input logic of_exp);
      n_total++;
      if (bus.Y === y_exp && bus.OF === of_exp)
         n_pass++;
      else
         $display("FAIL %s: got Y=%h OF=%b, expected Y=%h OF=%b",
                  name, bus.Y, bus.OF, y_exp, of_exp);
   endtask

   // Drive one op at the falling edge, let it be captured, sample just after.
   task automatic apply(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      bus.S = s;
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
   endtask

   // Reference model: exact integer arithmetic in 65 bits, wrapped to 64,
   // with overflow meaning the exact result does not fit in 64 signed bits.
   function automatic void ref_model(input logic [1:0] s, input logic [63:0] a,
                                     input logic [63:0] b,
                                     output logic [63:0] y, output logic of);
      logic signed [64:0] wa;
      logic signed [64:0] wb;
      logic signed [64:0] exact;
      wa = $signed({a[63], a});
      wb = $signed({b[63], b});
      of = 1'b0;
      case (s)
         2'b00: begin exact = wa + wb; y = exact[63:0]; of = (exact[64] != exact[63]); end
         2'b01: begin exact = wa - wb; y = exact[63:0]; of = (exact[64] != exact[63]); end
         2'b10: y = a & b;
         default: y = a ^ b;
      endcase
   endfunction

   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0: v = MAX;
         1: v = MIN;
         2: v = '0;
         3: v = NEG1;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      logic [63:0] ey;
      logic        eof;
      logic [1:0]  rs;
      logic [63:0] ra;
      logic [63:0] rb;

      // Boundary table: {name, S, A, B, expected Y, expected OF}
      tbl.push_back('{"add 1,-1",      2'b00, 64'd1, NEG1, 64'd0, 1'b0});
      tbl.push_back('{"sub 1,-1",      2'b01, 64'd1, NEG1, 64'd2, 1'b0});
      tbl.push_back('{"and 1,-1",      2'b10, 64'd1, NEG1, 64'd1, 1'b0});
      tbl.push_back('{"xor 1,-1",      2'b11, 64'd1, NEG1, NEG2,  1'b0});
      tbl.push_back('{"add max,max",   2'b00, MAX,   MAX,  NEG2,  1'b1});
      tbl.push_back('{"sub max,max",   2'b01, MAX,   MAX,  64'd0, 1'b0});
      tbl.push_back('{"and max,max",   2'b10, MAX,   MAX,  MAX,   1'b0});
      tbl.push_back('{"xor max,max",   2'b11, MAX,   MAX,  64'd0, 1'b0});
      tbl.push_back('{"add max,min",   2'b00, MAX,   MIN,  NEG1,  1'b0});
      tbl.push_back('{"sub max,min",   2'b01, MAX,   MIN,  NEG1,  1'b1});
      tbl.push_back('{"and max,min",   2'b10, MAX,   MIN,  64'd0, 1'b0});
      tbl.push_back('{"xor max,min",   2'b11, MAX,   MIN,  NEG1,  1'b0});
      tbl.push_back('{"add 0,min",     2'b00, 64'd0, MIN,  MIN,   1'b0});
      tbl.push_back('{"sub 0,min",     2'b01, 64'd0, MIN,  MIN,   1'b1});
      tbl.push_back('{"add min,0",     2'b00, MIN,   64'd0, MIN,  1'b0});
      tbl.push_back('{"sub min,0",     2'b01, MIN,   64'd0, MIN,  1'b0});
      tbl.push_back('{"and min,0",     2'b10, MIN,   64'd0, 64'd0, 1'b0});
      tbl.push_back('{"xor min,0",     2'b11, MIN,   64'd0, MIN,  1'b0});
      tbl.push_back('{"add min,min",   2'b00, MIN,   MIN,  64'd0, 1'b1});
      tbl.push_back('{"sub min,min",   2'b01, MIN,   MIN,  64'd0, 1'b0});
      tbl.push_back('{"and min,min",   2'b10, MIN,   MIN,  MIN,   1'b0});
      tbl.push_back('{"xor min,min",   2'b11, MIN,   MIN,  64'd0, 1'b0});

      // Reset with inputs already present: outputs must stay cleared.
      rst_n = 1'b0;
      bus.S = 2'b00;
      bus.A = MAX;
      bus.B = MAX;
      repeat (3) @(posedge clk);
      #1;
      check("reset state", 64'd0, 1'b0);

      // Release away from an edge; first edge afterwards yields MAX+MAX.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first op after reset", NEG2, 1'b1);

      // Asynchronous reset mid-cycle discards the held result at once.
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset mid-cycle", 64'd0, 1'b0);
      @(posedge clk);
      #1;
      check("reset held over edge", 64'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("resume after reset", NEG2, 1'b1);

      // Table vectors applied back to back, S changing every cycle.
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].s, tbl[i].a, tbl[i].b);
         check(tbl[i].name, tbl[i].y, tbl[i].of);
      end

      // Output holds between edges: sample again late in the cycle.
      apply(2'b01, 64'd0, MIN);
      #3;
      check("hold mid-cycle", MIN, 1'b1);

      // Random operations against the reference model.
      for (int i = 0; i < 300; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = pick_operand();
         rb = pick_operand();
         ref_model(rs, ra, rb, ey, eof);
         apply(rs, ra, rb);
         check($sformatf("random #%0d op=%0d", i, rs), ey, eof);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
